coproc_dispatcher: RTL and testbench
====================================

# coproc_dispatcher

Round-robin dispatcher that shares one multi-cycle coprocessor execution unit among `N_REQ` requesters. It accepts one request at a time from a rotating-priority winner, issues it to the unit, and waits for completion or a watchdog timeout. It then returns the result or an error to the owning requester. It sits between the requester ports and the single execution unit in the coprocessor.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2
- `DATA_W`, 32: operand/result width
- `TIMEOUT`, 16: maximum WAIT cycles before abort, ≥1

Ports:
- `in_clk`  in  1  clock; all state updates on rising edge
- `in_reset`  in  1  reset; asynchronous, active-low
- `in_req_valid`  in  N_REQ  per-requester request valid
- `in_req_data`  in  N_REQ*DATA_W  operands, requester i in bits [i*DATA_W +: DATA_W]
- `out_req_ready`  out  N_REQ  one-hot accept strobe
- `out_unit_start`  out  1  single-cycle start pulse to the unit
- `out_unit_operand`  out  DATA_W  operand to the unit; held from start until return to IDLE
- `out_unit_abort`  out  1  single-cycle abort pulse on timeout
- `in_unit_done`  in  1  unit completion pulse
- `in_unit_result`  in  DATA_W  result; valid with `in_unit_done`
- `out_rsp_valid`  out  N_REQ  one-hot response strobe to the owner
- `out_rsp_data`  out  DATA_W  response data
- `out_rsp_err`  out  1  response is a timeout error; qualified by `out_rsp_valid`

## Operation
- States: IDLE, GRANT, ISSUE, WAIT, RESP.
- Priority pointer `r_ptr`: one-hot, reset value bit 0.
- Winner selection: the first set bit of `in_req_valid` at or above `r_ptr`, circularly.
- IDLE:
  - If `in_req_valid` is nonzero: latch the winner in `r_owner`, register `out_req_ready` as the winner's one-hot bit, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If the owner's valid is still high, the handshake completes. Capture its operand into `out_unit_operand` and go to ISSUE.
  - If the owner's valid has dropped, cancel: return to IDLE with `r_ptr` unchanged.
  - `out_req_ready` clears on exit from GRANT.
- ISSUE:
  - `out_unit_start` is high for exactly this cycle.
  - Clear the watchdog counter, go to WAIT.
  - `in_unit_done` in this cycle is ignored.
- WAIT:
  - On `in_unit_done`: capture `in_unit_result` into `out_rsp_data`, set `out_rsp_err`=0, go to RESP.
  - Otherwise, when the counter equals `TIMEOUT`-1: pulse `out_unit_abort`, set `out_rsp_data`=0 and `out_rsp_err`=1, go to RESP.
  - Otherwise increment the counter.
  - If done and timeout occur in the same cycle, done wins and no abort is issued.
- RESP:
  - `out_rsp_valid`=one-hot `r_owner` for one cycle.
  - `r_ptr` <= `r_owner` rotated left by 1, wrapping the MSB to bit 0.
  - Go to IDLE.
- `in_unit_done` outside WAIT is ignored.
- Counter width: `$clog2(TIMEOUT+1)`.
- Undefined state encodings recover to IDLE with all outputs at reset values.

## Timing
- Reset (asynchronous assert): state IDLE, `r_ptr`=1, and all outputs 0 (`out_req_ready`, `out_unit_start`, `out_unit_abort`, `out_rsp_valid`, `out_rsp_data`, `out_rsp_err`, `out_unit_operand`).
- Reset mid-operation: the in-flight request is dropped and no response or abort is produced.
- All outputs are registered; none is combinational from inputs.
- Latency, with valid first sampled at edge k:
  - `out_req_ready` high during cycle k+1.
  - `out_unit_start` high during cycle k+2.
  - With done sampled at edge d, `out_rsp_valid` high during cycle d+1.
- Minimum occupancy per request: 5 cycles, with done arriving on the first WAIT cycle.
- Timeout: abort occurs on the `TIMEOUT`-th WAIT cycle; the error response follows in the next cycle.
- Requester rule: hold valid and data stable until ready. Data is sampled only in GRANT.

## Structure
- Shared package `coproc_pkg`: state enum (IDLE=0, GRANT=1, ISSUE=2, WAIT=3, RESP=4, 3-bit encoding) and the response error code constant.
- Sub-module `coproc_rr_pick`: combinational `N_REQ`-wide circular first-set-at-or-above-pointer selector, implemented with the doubled-vector subtract method. Inputs: request vector and one-hot pointer. Output: one-hot grant.
- The dispatcher FSM, watchdog counter and output registers form the top level.

## Test plan
- `N_REQ`=4, requests from 0 and 2 held, unit done 3 cycles after start → ready order 0, 2, 0, 2. Each `out_rsp_data` equals the unit result and `out_rsp_err`=0.
- All four requesters valid continuously from reset → grants in order 0, 1, 2, 3, 0. Each consecutive response is 5 cycles apart when done is immediate.
- Unit never asserts done, `TIMEOUT`=16 → one `out_unit_abort` pulse 16 cycles after start, then `out_rsp_valid`[owner] with `out_rsp_err`=1 and data 0, and the pointer advances.
- Done on the same cycle as the timeout → no abort, normal response with the result.
- Owner drops valid during GRANT → no start pulse, return to IDLE, the same requester index keeps priority.
- `in_reset` asserted during WAIT → all outputs 0 immediately. After release, the first grant goes to the lowest valid index at or above 0.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor dispatcher slice.
// Holds the dispatcher state encoding and the response error codes.
package coproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/coproc_rr_pick.sv
// Circular first-set-at-or-above-pointer selector for round-robin arbitration.
// Pure combinational; returns a one-hot grant, or zero when no request is set.
module coproc_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] ptr_ext;
    logic [2*N_REQ-1:0] grant_dbl;

    // Subtracting the pointer from the doubled vector clears the lowest set bit
    // at or above the pointer; the AND-NOT isolates it, the upper half covers wrap.
    assign req_dbl   = {req, req};
    assign ptr_ext   = {{N_REQ{1'b0}}, ptr};
    assign grant_dbl = req_dbl & ~(req_dbl - ptr_ext);
    assign grant     = grant_dbl[N_REQ-1:0] | grant_dbl[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/coproc_dispatcher.sv
// Shares one multi-cycle execution unit among N_REQ requesters with round-robin
// priority, a watchdog abort, and registered per-owner responses.
module coproc_dispatcher
    import coproc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                    in_clk,
    input  logic                    in_reset,
    input  logic [N_REQ-1:0]        in_req_valid,
    input  logic [N_REQ*DATA_W-1:0] in_req_data,
    output logic [N_REQ-1:0]        out_req_ready,
    output logic                    out_unit_start,
    output logic [DATA_W-1:0]       out_unit_operand,
    output logic                    out_unit_abort,
    input  logic                    in_unit_done,
    input  logic [DATA_W-1:0]       in_unit_result,
    output logic [N_REQ-1:0]        out_rsp_valid,
    output logic [DATA_W-1:0]       out_rsp_data,
    output logic                    out_rsp_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    state_e             state_d;
    logic [N_REQ-1:0]   r_ptr;
    logic [N_REQ-1:0]   ptr_d;
    logic [N_REQ-1:0]   r_owner;
    logic [N_REQ-1:0]   owner_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [N_REQ-1:0]   pick;
    logic               owner_valid;
    logic [DATA_W-1:0]  owner_data;
    logic               timeout_hit;

    logic [N_REQ-1:0]   req_ready_d;
    logic               unit_start_d;
    logic [DATA_W-1:0]  unit_operand_d;
    logic               unit_abort_d;
    logic [N_REQ-1:0]   rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               rsp_err_d;

    coproc_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (in_req_valid),
        .ptr   (r_ptr),
        .grant (pick)
    );

    assign owner_valid = |(in_req_valid & r_owner);
    assign timeout_hit = (r_cnt == CNT_LAST);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner[i]) begin
                owner_data = owner_data | in_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|in_req_valid) state_d = ST_GRANT;
            ST_GRANT: state_d = owner_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (in_unit_done || timeout_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values for every registered output; pulses default low, data holds.
    always_comb begin
        req_ready_d    = '0;
        unit_start_d   = 1'b0;
        unit_abort_d   = 1'b0;
        rsp_valid_d    = '0;
        unit_operand_d = out_unit_operand;
        rsp_data_d     = out_rsp_data;
        rsp_err_d      = out_rsp_err;
        owner_d        = r_owner;
        ptr_d          = r_ptr;
        cnt_d          = r_cnt;
        case (state_q)
            ST_IDLE: begin
                if (|in_req_valid) begin
                    owner_d     = pick;
                    req_ready_d = pick;
                end
            end
            ST_GRANT: begin
                if (owner_valid) begin
                    unit_operand_d = owner_data;
                    unit_start_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                // Done takes precedence over a coincident watchdog expiry.
                if (in_unit_done) begin
                    rsp_data_d  = in_unit_result;
                    rsp_err_d   = RSP_ERR_NONE;
                    rsp_valid_d = r_owner;
                end else if (timeout_hit) begin
                    unit_abort_d = 1'b1;
                    rsp_data_d   = '0;
                    rsp_err_d    = RSP_ERR_TIMEOUT;
                    rsp_valid_d  = r_owner;
                end else begin
                    cnt_d = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d = {r_owner[N_REQ-2:0], r_owner[N_REQ-1]};
            end
            default: begin
                unit_operand_d = '0;
                rsp_data_d     = '0;
                rsp_err_d      = 1'b0;
                owner_d        = '0;
                cnt_d          = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_ptr            <= {{(N_REQ-1){1'b0}}, 1'b1};
            r_owner          <= '0;
            r_cnt            <= '0;
            out_req_ready    <= '0;
            out_unit_start   <= 1'b0;
            out_unit_operand <= '0;
            out_unit_abort   <= 1'b0;
            out_rsp_valid    <= '0;
            out_rsp_data     <= '0;
            out_rsp_err      <= 1'b0;
        end else begin
            r_ptr            <= ptr_d;
            r_owner          <= owner_d;
            r_cnt            <= cnt_d;
            out_req_ready    <= req_ready_d;
            out_unit_start   <= unit_start_d;
            out_unit_operand <= unit_operand_d;
            out_unit_abort   <= unit_abort_d;
            out_rsp_valid    <= rsp_valid_d;
            out_rsp_data     <= rsp_data_d;
            out_rsp_err      <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_coproc_dispatcher.sv
// Directed bench for coproc_dispatcher: round-robin order, latency, watchdog,
// GRANT cancel and mid-operation reset, with outputs sampled on falling edges.
module tb_coproc_dispatcher;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002;
    localparam logic [31:0] D3 = 32'h4444_0003;

    logic                    in_clk;
    logic                    in_reset;
    logic [N_REQ-1:0]        in_req_valid;
    logic [N_REQ*DATA_W-1:0] in_req_data;
    logic [N_REQ-1:0]        out_req_ready;
    logic                    out_unit_start;
    logic [DATA_W-1:0]       out_unit_operand;
    logic                    out_unit_abort;
    logic                    in_unit_done;
    logic [DATA_W-1:0]       in_unit_result;
    logic [N_REQ-1:0]        out_rsp_valid;
    logic [DATA_W-1:0]       out_rsp_data;
    logic                    out_rsp_err;

    int total;
    int bad;
    int cyc;
    int rsp_cyc;
    int prev_rsp_cyc;

    coproc_dispatcher #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .in_clk           (in_clk),
        .in_reset         (in_reset),
        .in_req_valid     (in_req_valid),
        .in_req_data      (in_req_data),
        .out_req_ready    (out_req_ready),
        .out_unit_start   (out_unit_start),
        .out_unit_operand (out_unit_operand),
        .out_unit_abort   (out_unit_abort),
        .in_unit_done     (in_unit_done),
        .in_unit_result   (in_unit_result),
        .out_rsp_valid    (out_rsp_valid),
        .out_rsp_data     (out_rsp_data),
        .out_rsp_err      (out_rsp_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge in_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   64'(out_req_ready),    64'd0);
        check({tag, "_start"},   64'(out_unit_start),   64'd0);
        check({tag, "_abort"},   64'(out_unit_abort),   64'd0);
        check({tag, "_rspv"},    64'(out_rsp_valid),    64'd0);
        check({tag, "_rspd"},    64'(out_rsp_data),     64'd0);
        check({tag, "_rspe"},    64'(out_rsp_err),      64'd0);
        check({tag, "_operand"}, 64'(out_unit_operand), 64'd0);
    endtask

    // Called at a falling edge with the DUT in IDLE and valid already driven.
    // A done pulse is driven during ISSUE, which the DUT must ignore.
    task automatic serve(input logic [3:0] exp_owner, input logic [31:0] exp_operand,
                         input int done_wait, input logic [31:0] result);
        step();
        check("ready", 64'(out_req_ready), 64'(exp_owner));
        check("start_early", 64'(out_unit_start), 64'd0);
        step();
        check("start", 64'(out_unit_start), 64'd1);
        check("ready_clear", 64'(out_req_ready), 64'd0);
        check("operand", 64'(out_unit_operand), 64'(exp_operand));
        in_unit_done   = 1'b1;
        in_unit_result = 32'hDEAD_BEEF;
        step();
        in_unit_done = 1'b0;
        check("start_pulse", 64'(out_unit_start), 64'd0);
        for (int i = 1; i < done_wait; i++) step();
        in_unit_done   = 1'b1;
        in_unit_result = result;
        step();
        in_unit_done = 1'b0;
        check("rsp_valid", 64'(out_rsp_valid), 64'(exp_owner));
        check("rsp_data", 64'(out_rsp_data), 64'(result));
        check("rsp_err", 64'(out_rsp_err), 64'd0);
        check("no_abort", 64'(out_unit_abort), 64'd0);
        rsp_cyc = cyc;
        step();
        check("rsp_once", 64'(out_rsp_valid), 64'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        in_reset     = 1'b1;
        in_req_valid = '0;
        in_req_data  = {D3, D2, D1, D0};
        in_unit_done = 1'b0;
        in_unit_result = '0;

        // Power-on reset values
        #2 in_reset = 1'b0;
        #1 check_all_zero("reset");
        step();
        step();
        in_reset = 1'b1;

        // Requesters 0 and 2 held: alternate 0,2,0,2, done 3 cycles after start
        in_req_valid = 4'b0101;
        serve(4'b0001, D0, 3, 32'h0000_00A0);
        serve(4'b0100, D2, 3, 32'h0000_00A2);
        serve(4'b0001, D0, 3, 32'h0000_00B0);
        serve(4'b0100, D2, 3, 32'h0000_00B2);

        // All four valid from reset with immediate done: 0,1,2,3,0, 5 cycles apart
        in_req_valid = '0;
        in_reset     = 1'b0;
        step();
        in_reset     = 1'b1;
        in_req_valid = 4'b1111;
        serve(4'b0001, D0, 1, 32'h0000_0C00);
        prev_rsp_cyc = rsp_cyc;
        serve(4'b0010, D1, 1, 32'h0000_0C01);
        check("spacing_01", 64'(rsp_cyc - prev_rsp_cyc), 64'd5);
        prev_rsp_cyc = rsp_cyc;
        serve(4'b0100, D2, 1, 32'h0000_0C02);
        check("spacing_12", 64'(rsp_cyc - prev_rsp_cyc), 64'd5);
        prev_rsp_cyc = rsp_cyc;
        serve(4'b1000, D3, 1, 32'h0000_0C03);
        check("spacing_23", 64'(rsp_cyc - prev_rsp_cyc), 64'd5);
        prev_rsp_cyc = rsp_cyc;
        serve(4'b0001, D0, 1, 32'h0000_0C04);
        check("spacing_30", 64'(rsp_cyc - prev_rsp_cyc), 64'd5);

        // Unit never completes: 16 quiet WAIT cycles, then abort with error response
        in_req_valid = 4'b0010;
        step();
        check("to_ready", 64'(out_req_ready), 64'b0010);
        step();
        check("to_start", 64'(out_unit_start), 64'd1);
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check("to_wait_abort", 64'(out_unit_abort), 64'd0);
            check("to_wait_rspv", 64'(out_rsp_valid), 64'd0);
        end
        step();
        check("to_abort", 64'(out_unit_abort), 64'd1);
        check("to_rspv", 64'(out_rsp_valid), 64'b0010);
        check("to_rspe", 64'(out_rsp_err), 64'd1);
        check("to_rspd", 64'(out_rsp_data), 64'd0);
        step();
        check("to_abort_once", 64'(out_unit_abort), 64'd0);
        check("to_rsp_once", 64'(out_rsp_valid), 64'd0);

        // Pointer moved past 1, so 2 wins; done on the 16th WAIT cycle beats the abort
        in_req_valid = 4'b0111;
        serve(4'b0100, D2, TIMEOUT, 32'h0000_0E16);

        // Owner 3 drops valid in GRANT: no start, and 3 keeps priority over 1
        in_req_valid = 4'b1000;
        step();
        check("cancel_ready", 64'(out_req_ready), 64'b1000);
        in_req_valid = '0;
        step();
        check("cancel_ready_clear", 64'(out_req_ready), 64'd0);
        check("cancel_no_start", 64'(out_unit_start), 64'd0);
        step();
        check("cancel_no_start2", 64'(out_unit_start), 64'd0);
        in_req_valid = 4'b1010;
        serve(4'b1000, D3, 1, 32'h0000_0F03);

        // Serve 0 so the pointer sits at 1, then reset in the middle of WAIT
        in_req_valid = 4'b0001;
        serve(4'b0001, D0, 1, 32'h0000_0A00);
        in_req_valid = 4'b0100;
        step();
        check("rst_ready", 64'(out_req_ready), 64'b0100);
        step();
        step();
        step();
        in_reset = 1'b0;
        #1 check_all_zero("midrst");
        in_unit_done   = 1'b1;
        in_unit_result = 32'h0000_0BAD;
        step();
        in_unit_done = 1'b0;
        check("midrst_no_rsp", 64'(out_rsp_valid), 64'd0);
        check("midrst_no_abort", 64'(out_unit_abort), 64'd0);
        in_reset     = 1'b1;
        in_req_valid = 4'b1101;
        serve(4'b0001, D0, 2, 32'h0000_0A55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
